light_sampler: RTL and testbench

Periodic sampling controller for the light-sensor path. It triggers the 8-bit ADC SPI master at a fixed rate and captures each converted byte once chip-select returns high. The captured bytes pass through a 4-sample moving average and a hysteresis comparator, producing a filtered light level and a debounced `dark` flag for downstream control logic. The block sits directly upstream and downstream of the SPI master: it drives the master's `start` and consumes its `cs_n` and `adc_data`.

---
 rtl/light_sampler.sv | 166 ++++++++++++++++
 tb/tb_light_sampler.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/light_sampler.sv
// Periodic light-sensor sampler: triggers the ADC SPI master, captures each byte,
// and produces a 4-sample moving average with a hysteresis-filtered dark flag.
module light_sampler #(
  parameter int unsigned SAMPLE_PERIOD = 50000,
  parameter int unsigned TIMEOUT       = 1023,
  parameter logic [7:0]  TH_ON         = 8'h40,
  parameter logic [7:0]  TH_OFF        = 8'h50
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       en,
  input  logic       cs_n,
  input  logic [7:0] adc_data,
  output logic       start,
  output logic [7:0] light_avg,
  output logic       avg_valid,
  output logic       dark,
  output logic       timeout_err
);

  localparam int unsigned DW    = 8;
  localparam int unsigned SUM_W = DW + 2;
  localparam int unsigned CNT_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int unsigned WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    WAIT_CS = 3'd2,
    BUSY    = 3'd3,
    ACC     = 3'd4,
    UPD     = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WD_W-1:0]     wd_q, wd_d;
  logic [DW-1:0]       sample_q, sample_d;
  logic [3:0][DW-1:0]  win_q, win_d;
  logic [SUM_W-1:0]    sum_q, sum_d;
  logic                primed_q, primed_d;
  logic                start_q, start_d;
  logic [DW-1:0]       avg_q, avg_d;
  logic                valid_q, valid_d;
  logic                dark_q, dark_d;
  logic                err_q, err_d;

  logic                tick_c;
  logic                wd_exp_c;
  logic [DW-1:0]       avg_new_c;

  assign tick_c    = en && (cnt_q == CNT_W'(SAMPLE_PERIOD - 1));
  assign wd_exp_c  = (wd_q == WD_W'(TIMEOUT - 1));
  assign avg_new_c = sum_q[SUM_W-1:2];

  // Next-state and datapath updates; ticks outside IDLE are simply ignored
  always_comb begin
    state_d  = state_q;
    cnt_d    = en ? (tick_c ? '0 : cnt_q + CNT_W'(1)) : '0;
    wd_d     = wd_q;
    sample_d = sample_q;
    win_d    = win_q;
    sum_d    = sum_q;
    primed_d = primed_q;
    start_d  = 1'b0;
    avg_d    = avg_q;
    valid_d  = 1'b0;
    dark_d   = dark_q;
    err_d    = err_q;

    case (state_q)
      IDLE: begin
        if (tick_c) state_d = REQ;
      end
      REQ: begin
        state_d = WAIT_CS;
        wd_d    = '0;
      end
      WAIT_CS: begin
        if (wd_exp_c) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          wd_d = wd_q + WD_W'(1);
          if (!cs_n) state_d = BUSY;
        end
      end
      BUSY: begin
        if (wd_exp_c) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          wd_d = wd_q + WD_W'(1);
          if (cs_n) begin
            state_d  = ACC;
            sample_d = adc_data;
          end
        end
      end
      ACC: begin
        state_d = UPD;
        // First sample fills the whole window so the average starts settled
        if (!primed_q) begin
          win_d    = {4{sample_q}};
          sum_d    = {sample_q, 2'b00};
          primed_d = 1'b1;
        end else begin
          win_d = {win_q[2:0], sample_q};
          sum_d = sum_q + SUM_W'(sample_q) - SUM_W'(win_q[3]);
        end
      end
      UPD: begin
        state_d = IDLE;
        avg_d   = avg_new_c;
        valid_d = 1'b1;
        err_d   = 1'b0;
        if (avg_new_c < TH_ON) begin
          dark_d = 1'b1;
        end else if (avg_new_c >= TH_OFF) begin
          dark_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    start_d = (state_d == REQ);
    if (!en) err_d = 1'b0;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      wd_q     <= '0;
      sample_q <= '0;
      win_q    <= '0;
      sum_q    <= '0;
      primed_q <= 1'b0;
      start_q  <= 1'b0;
      avg_q    <= '0;
      valid_q  <= 1'b0;
      dark_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wd_q     <= wd_d;
      sample_q <= sample_d;
      win_q    <= win_d;
      sum_q    <= sum_d;
      primed_q <= primed_d;
      start_q  <= start_d;
      avg_q    <= avg_d;
      valid_q  <= valid_d;
      dark_q   <= dark_d;
      err_q    <= err_d;
    end
  end

  assign start       = start_q;
  assign light_avg   = avg_q;
  assign avg_valid   = valid_q;
  assign dark        = dark_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_light_sampler.sv
// Scoreboard bench for light_sampler: directed ADC bytes with hand-computed
// averages and dark flags, plus a second instance exercising sample overrun.
module tb_light_sampler;

  localparam int unsigned PERIOD = 100;

  logic       clk = 1'b0;
  logic       n_rst = 1'b1;
  logic       en;
  logic       cs_n;
  logic [7:0] adc_data;
  logic       start;
  logic [7:0] light_avg;
  logic       avg_valid;
  logic       dark;
  logic       timeout_err;

  logic       rst2 = 1'b1;
  logic       en2;
  logic       cs_n2;
  logic [7:0] adc2;
  logic       start2;
  logic [7:0] avg2;
  logic       valid2;
  logic       dark2;
  logic       err2;

  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  int         n_valid = 0;
  int         start_cnt = 0;
  int         last_start_cyc = 0;
  int         wcs_entry = 0;
  int         rise_cyc = 0;
  int         prev2 = -1;
  int         ovr_n = 0;
  logic       start_prev = 1'b0;
  logic       err_prev = 1'b0;
  logic       spi_respond;
  logic [7:0] spi_byte;
  logic [8:0] exp_q[$];
  logic [8:0] e;

  light_sampler #(.SAMPLE_PERIOD(PERIOD), .TIMEOUT(20), .TH_ON(8'h40), .TH_OFF(8'h50)) u_dut (
    .clk(clk), .n_rst(n_rst), .en(en), .cs_n(cs_n), .adc_data(adc_data),
    .start(start), .light_avg(light_avg), .avg_valid(avg_valid), .dark(dark),
    .timeout_err(timeout_err)
  );

  light_sampler #(.SAMPLE_PERIOD(PERIOD), .TIMEOUT(200), .TH_ON(8'h40), .TH_OFF(8'h50)) u_ovr (
    .clk(clk), .n_rst(rst2), .en(en2), .cs_n(cs_n2), .adc_data(adc2),
    .start(start2), .light_avg(avg2), .avg_valid(valid2), .dark(dark2),
    .timeout_err(err2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // SPI master model for the main instance: cs_n low 10 cycles, then the byte
  initial begin
    cs_n = 1'b1;
    adc_data = 8'h00;
    forever begin
      @(negedge clk);
      if (start && spi_respond) begin
        @(posedge clk);
        #1 cs_n = 1'b0;
        adc_data = ~spi_byte;
        repeat (10) @(posedge clk);
        #1 cs_n = 1'b1;
        adc_data = spi_byte;
        rise_cyc = cyc;
      end
    end
  end

  // Slow SPI model for the overrun instance: cs_n low 150 cycles
  initial begin
    cs_n2 = 1'b1;
    adc2 = 8'h00;
    forever begin
      @(negedge clk);
      if (start2) begin
        @(posedge clk);
        #1 cs_n2 = 1'b0;
        adc2 = 8'h00;
        repeat (150) @(posedge clk);
        #1 cs_n2 = 1'b1;
        adc2 = 8'h70;
      end
    end
  end

  // Monitor: pops the scoreboard on every avg_valid
  always @(negedge clk) begin
    if (start) begin
      chk("start_width", int'(start_prev), 0);
      start_cnt++;
      last_start_cyc = cyc;
      wcs_entry = cyc + 1;
    end
    start_prev = start;
    if (avg_valid) begin
      n_valid++;
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("light_avg", int'(light_avg), int'(e[8:1]));
        chk("dark", int'(dark), int'(e[0]));
        chk("valid_latency", cyc - rise_cyc, 3);
      end
    end
    if (timeout_err && !err_prev) chk("timeout_latency", cyc - wcs_entry, 20);
    err_prev = timeout_err;
  end

  always @(negedge clk) begin
    if (start2) begin
      if (prev2 >= 0) begin
        chk("ovr_start_interval", cyc - prev2, 200);
        ovr_n++;
      end
      prev2 = cyc;
    end
    if (valid2) begin
      chk("ovr_avg", int'(avg2), 8'h70);
      chk("ovr_dark", int'(dark2), 0);
      chk("ovr_err", int'(err2), 0);
    end
  end

  task automatic do_sample(input logic [7:0] b, input logic [7:0] ea, input logic ed);
    int n0;
    int s0;
    n0 = n_valid;
    s0 = start_cnt;
    spi_byte = b;
    exp_q.push_back({ea, ed});
    for (int i = 0; i < 400 && n_valid == n0; i++) @(posedge clk);
    chk("sample_done", int'(n_valid != n0), 1);
    if (n_valid == n0) exp_q.delete();
    chk("start_count", start_cnt - s0, 1);
    #1 chk("err_clear", int'(timeout_err), 0);
  endtask

  initial begin
    int n0;
    int s0;
    int s1;
    int r;
    en = 1'b1;
    en2 = 1'b1;
    spi_respond = 1'b1;
    spi_byte = 8'h00;
    #2 n_rst = 1'b0;
    rst2 = 1'b0;
    #2;
    chk("rst_start", int'(start), 0);
    chk("rst_avg", int'(light_avg), 0);
    chk("rst_valid", int'(avg_valid), 0);
    chk("rst_dark", int'(dark), 0);
    chk("rst_err", int'(timeout_err), 0);
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;
    rst2 = 1'b1;

    // Basic sample and averaging
    do_sample(8'h80, 8'h80, 1'b0);
    do_sample(8'h00, 8'h60, 1'b0);
    do_sample(8'h00, 8'h40, 1'b0);
    do_sample(8'h00, 8'h20, 1'b1);
    do_sample(8'h00, 8'h00, 1'b1);

    // Hysteresis: averages 0C,18,24,30,48,50,48,3F
    do_sample(8'h30, 8'h0C, 1'b1);
    do_sample(8'h30, 8'h18, 1'b1);
    do_sample(8'h30, 8'h24, 1'b1);
    do_sample(8'h30, 8'h30, 1'b1);
    do_sample(8'h90, 8'h48, 1'b1);
    do_sample(8'h50, 8'h50, 1'b0);
    do_sample(8'h10, 8'h48, 1'b0);
    do_sample(8'h0C, 8'h3F, 1'b1);

    // Timeout: SPI never answers
    spi_respond = 1'b0;
    n0 = n_valid;
    for (int i = 0; i < 300 && !timeout_err; i++) @(posedge clk);
    #1 chk("timeout_set", int'(timeout_err), 1);
    chk("no_valid_on_timeout", n_valid - n0, 0);
    spi_respond = 1'b1;
    do_sample(8'h90, 8'h3F, 1'b1);

    // Reset in the middle of BUSY
    spi_byte = 8'h55;
    for (int i = 0; i < 300 && cs_n; i++) @(posedge clk);
    chk("busy_reached", int'(cs_n), 0);
    repeat (3) @(posedge clk);
    #2 n_rst = 1'b0;
    #1;
    chk("mid_rst_start", int'(start), 0);
    chk("mid_rst_avg", int'(light_avg), 0);
    chk("mid_rst_valid", int'(avg_valid), 0);
    chk("mid_rst_dark", int'(dark), 0);
    chk("mid_rst_err", int'(timeout_err), 0);
    @(posedge clk);
    #1 n_rst = 1'b1;
    r = cyc;
    spi_byte = 8'h20;
    exp_q.push_back({8'h20, 1'b1});
    n0 = n_valid;
    s0 = start_cnt;
    for (int i = 0; i < 300 && start_cnt == s0; i++) @(posedge clk);
    chk("rst_to_start", last_start_cyc - r, int'(PERIOD));
    for (int i = 0; i < 400 && n_valid == n0; i++) @(posedge clk);
    chk("reprime_done", int'(n_valid != n0), 1);
    if (n_valid == n0) exp_q.delete();

    // en dropped during BUSY: transaction completes, no new requests
    n0 = n_valid;
    s0 = start_cnt;
    spi_byte = 8'h40;
    exp_q.push_back({8'h28, 1'b1});
    for (int i = 0; i < 300 && cs_n; i++) @(posedge clk);
    #1 en = 1'b0;
    for (int i = 0; i < 400 && n_valid == n0; i++) @(posedge clk);
    chk("en_off_valid", n_valid - n0, 1);
    if (n_valid == n0) exp_q.delete();
    s1 = start_cnt;
    chk("en_off_start", s1 - s0, 1);
    repeat (300) @(posedge clk);
    chk("no_start_after_en", start_cnt - s1, 0);
    chk("ovr_intervals_seen", int'(ovr_n >= 2), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
